station_select: RTL and testbench
=================================

# station_select

Registered start/destination picker for the railway map. It watches keyboard scancodes and the on-screen cursor position. On each Enter press it scans a station coordinate table for the lowest-index station within a configurable radius of the cursor. It captures a begin station, then an end station, and hands the pair to the shortest-path engine through a valid/ready handshake.

## Interface
- N_STATIONS, 44, number of table entries scanned (1..2^IDX_W)
- IDX_W, 6, station index width
- COORD_W, 10, pixel coordinate width
- HIT_R, 1, hit radius in pixels, inclusive, per axis
- ENTER_CODE, 8'd40, scancode that selects
- ESC_CODE, 8'd41, scancode that clears the selection
- Clk  in  1  system clock; single clock domain
- Reset_n  in  1  asynchronous, active-low reset
- keycode  in  8  current keyboard scancode, level
- cursor_x, cursor_y  in  COORD_W  cursor position
- tbl_addr  out  IDX_W  station table read address
- tbl_x, tbl_y  in  COORD_W  station coordinates; combinational read of tbl_addr, same cycle
- busy  out  1  scan in progress
- miss  out  1  one-cycle pulse when a scan finds no station
- begin_set  out  1  begin station captured
- begin_idx  out  IDX_W; begin_x, begin_y  out  COORD_W  captured begin station
- end_idx  out  IDX_W; end_x, end_y  out  COORD_W  captured end station
- pair_valid  out  1  begin/end pair available to the path engine
- pair_ready  in  1  path engine accepts the pair

## Operation
- Key edges:
  - prev_key register holds last cycle's keycode.
  - enter_edge = (keycode==ENTER_CODE) && (prev_key!=ENTER_CODE).
  - esc_edge is defined the same way for ESC_CODE.
  - Holding a key produces exactly one edge.
- States:
  - WAIT_B: no begin selected.
  - SCAN_B
  - WAIT_E: begin held.
  - SCAN_E
  - PAIR
- Transitions:
  - WAIT_B + enter_edge -> SCAN_B; cursor latched into cur_x/cur_y.
  - WAIT_E + enter_edge -> SCAN_E; cursor latched into cur_x/cur_y.
- Scan:
  - Scan counter k runs 0..N_STATIONS-1; tbl_addr=k.
  - Hit when |cur_x-tbl_x|<=HIT_R and |cur_y-tbl_y|<=HIT_R.
  - Absolute difference is computed as larger minus smaller, unsigned, COORD_W bits. There is no wrap at coordinate 0 or at max.
  - The first hit terminates the scan, so the lowest index wins.
  - SCAN_B hit -> store begin_idx/x/y (the table coordinates, not the cursor), set begin_set, go to WAIT_E.
  - SCAN_E hit with k!=begin_idx -> store end_idx/x/y, go to PAIR.
  - SCAN_E hit with k==begin_idx -> treated as a miss.
  - No hit after k=N_STATIONS-1 -> miss pulse; return to the originating WAIT state, registers unchanged.
- PAIR:
  - pair_valid=1, held stable with begin/end outputs until pair_ready.
  - On the cycle pair_valid && pair_ready: go to WAIT_B, clear begin_set.
  - begin/end idx/x/y keep their values until overwritten.
- esc_edge:
  - From any state, go to WAIT_B and clear begin_set; abort any scan; drop pair_valid.
  - esc_edge beats enter_edge and pair_ready in the same cycle.
- Ignored events:
  - enter_edge during SCAN_B, SCAN_E or PAIR is ignored, not queued.
  - A cursor change during a scan has no effect, since the latched copy is used.
- busy=1 exactly in SCAN_B/SCAN_E.
- tbl_addr=0 outside scans.

## Timing
- Reset values:
  - State WAIT_B.
  - All outputs and all internal registers 0.
  - prev_key=0, so a key already held at release of reset produces an edge on the first clock.
- Scan start: enter_edge in cycle t -> scan with k=0 in cycle t+1.
- Station k compare: cycle t+1+k.
- Begin hit at k: begin outputs and begin_set valid from t+2+k.
- End hit at k: pair_valid high from t+2+k.
- Miss: miss high for cycle t+1+N_STATIONS only; busy low that same cycle.
- Worst-case scan: N_STATIONS cycles.
- pair_ready is sampled only while pair_valid=1. Acceptance at cycle u -> pair_valid=0 at u+1.
- Reset assertion mid-scan or in PAIR forces the reset values immediately (asynchronous).

## Test plan
- **Begin then end:**
  - Table: 3=(465,186), 7=(530,301), others far away. Cursor (466,185); Enter for 1 cycle.
    -> begin_idx=3, begin_x/y=465/186 at t+5; begin_set=1.
  - Cursor (529,302); Enter.
    -> end_idx=7, pair_valid=1 at t'+9.
  - pair_ready=1 -> WAIT_B, begin_set=0.
- **Radius boundary:**
  - Cursor (467,186) with HIT_R=1 -> miss pulse at t+1+N_STATIONS, state WAIT_B.
  - Cursor (464,187) -> hit on station 3.
- **Overlap priority and same-station end:**
  - Stations 5 and 6 both =(436,416). Enter at (436,416) -> begin_idx=5.
  - Enter again at the same spot -> miss, still WAIT_E.
- **Held key and mid-scan Enter:**
  - Enter held 200 cycles -> exactly one scan.
  - Second Enter edge during SCAN_B ignored; busy unchanged.
- **Escape and backpressure:**
  - In PAIR with pair_ready=0 for 50 cycles -> outputs stable.
  - ESC and pair_ready in the same cycle -> pair_valid=0, WAIT_B.
- **Async reset mid-scan:**
  - Reset_n low at k=10 -> all outputs 0 before the next Clk edge.
  - Release, then Enter -> normal scan from k=0.

Source files
------------

// File: rtl/station_select.sv
// station_select
//
// Start/destination picker for the railway map. Each Enter press latches the
// cursor and scans the station coordinate table, one entry per clock, for the
// lowest-index station within HIT_R pixels of the cursor on both axes. The
// first accepted pick becomes the begin station, the second the end station.
// The begin/end pair is then offered to the shortest-path engine with a
// valid/ready handshake. Escape clears the selection from any state.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   keycode               current keyboard scancode (level)
//   cursor_x, cursor_y    on-screen cursor position
//   tbl_addr              station table read address (0 outside scans)
//   tbl_x, tbl_y          station coordinates, combinational read of tbl_addr
//   busy                  scan in progress
//   miss                  one-cycle pulse when a scan ends without a station
//   begin_set             begin station captured
//   begin_idx/x/y         captured begin station
//   end_idx/x/y           captured end station
//   pair_valid            begin/end pair offered to the path engine
//   pair_ready            path engine accepts the pair
module station_select #(
  parameter int         N_STATIONS = 44,
  parameter int         IDX_W      = 6,
  parameter int         COORD_W    = 10,
  parameter int         HIT_R      = 1,
  parameter logic [7:0] ENTER_CODE = 8'd40,
  parameter logic [7:0] ESC_CODE   = 8'd41
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         keycode,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  output logic [IDX_W-1:0]   tbl_addr,
  input  logic [COORD_W-1:0] tbl_x,
  input  logic [COORD_W-1:0] tbl_y,
  output logic               busy,
  output logic               miss,
  output logic               begin_set,
  output logic [IDX_W-1:0]   begin_idx,
  output logic [COORD_W-1:0] begin_x,
  output logic [COORD_W-1:0] begin_y,
  output logic [IDX_W-1:0]   end_idx,
  output logic [COORD_W-1:0] end_x,
  output logic [COORD_W-1:0] end_y,
  output logic               pair_valid,
  input  logic               pair_ready
);

  typedef enum logic [2:0] {
    WAIT_B = 3'd0,
    SCAN_B = 3'd1,
    WAIT_E = 3'd2,
    SCAN_E = 3'd3,
    PAIR   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           prev_key_reg;
  logic [IDX_W-1:0]     k_reg, k_next;
  logic [COORD_W-1:0]   cur_x_reg, cur_x_next;
  logic [COORD_W-1:0]   cur_y_reg, cur_y_next;
  logic                 begin_set_reg, begin_set_next;
  logic [IDX_W-1:0]     begin_idx_reg, begin_idx_next;
  logic [COORD_W-1:0]   begin_x_reg, begin_x_next;
  logic [COORD_W-1:0]   begin_y_reg, begin_y_next;
  logic [IDX_W-1:0]     end_idx_reg, end_idx_next;
  logic [COORD_W-1:0]   end_x_reg, end_x_next;
  logic [COORD_W-1:0]   end_y_reg, end_y_next;
  logic                 miss_reg, miss_next;

  logic                 enter_edge, esc_edge;
  logic [COORD_W-1:0]   dx, dy;
  logic                 hit, last_k, scanning;

  // A held key yields exactly one edge: the previous-cycle copy suppresses
  // repeats. prev_key resets to 0, so a key held through reset release
  // fires on the first clock.
  assign enter_edge = (keycode == ENTER_CODE) && (prev_key_reg != ENTER_CODE);
  assign esc_edge   = (keycode == ESC_CODE)   && (prev_key_reg != ESC_CODE);

  // Distance is larger-minus-smaller so coordinates near 0 or the top of the
  // range never wrap into a false hit.
  assign dx     = (cur_x_reg >= tbl_x) ? (cur_x_reg - tbl_x) : (tbl_x - cur_x_reg);
  assign dy     = (cur_y_reg >= tbl_y) ? (cur_y_reg - tbl_y) : (tbl_y - cur_y_reg);
  assign hit    = (dx <= COORD_W'(HIT_R)) && (dy <= COORD_W'(HIT_R));
  assign last_k = (k_reg == IDX_W'(N_STATIONS - 1));

  assign scanning = (state_reg == SCAN_B) || (state_reg == SCAN_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT_B;
      prev_key_reg  <= '0;
      k_reg         <= '0;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      begin_set_reg <= 1'b0;
      begin_idx_reg <= '0;
      begin_x_reg   <= '0;
      begin_y_reg   <= '0;
      end_idx_reg   <= '0;
      end_x_reg     <= '0;
      end_y_reg     <= '0;
      miss_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_key_reg  <= keycode;
      k_reg         <= k_next;
      cur_x_reg     <= cur_x_next;
      cur_y_reg     <= cur_y_next;
      begin_set_reg <= begin_set_next;
      begin_idx_reg <= begin_idx_next;
      begin_x_reg   <= begin_x_next;
      begin_y_reg   <= begin_y_next;
      end_idx_reg   <= end_idx_next;
      end_x_reg     <= end_x_next;
      end_y_reg     <= end_y_next;
      miss_reg      <= miss_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    cur_x_next     = cur_x_reg;
    cur_y_next     = cur_y_reg;
    begin_set_next = begin_set_reg;
    begin_idx_next = begin_idx_reg;
    begin_x_next   = begin_x_reg;
    begin_y_next   = begin_y_reg;
    end_idx_next   = end_idx_reg;
    end_x_next     = end_x_reg;
    end_y_next     = end_y_reg;
    miss_next      = 1'b0;

    if (esc_edge) begin
      // Escape wins over everything in flight, including a hit found in
      // this very cycle and a simultaneous pair_ready.
      state_next     = WAIT_B;
      begin_set_next = 1'b0;
      k_next         = '0;
    end else begin
      case (state_reg)
        WAIT_B: begin
          if (enter_edge) begin
            state_next = SCAN_B;
            k_next     = '0;
            cur_x_next = cursor_x;
            cur_y_next = cursor_y;
          end
        end
        WAIT_E: begin
          if (enter_edge) begin
            state_next = SCAN_E;
            k_next     = '0;
            cur_x_next = cursor_x;
            cur_y_next = cursor_y;
          end
        end
        SCAN_B: begin
          if (hit) begin
            state_next     = WAIT_E;
            begin_set_next = 1'b1;
            begin_idx_next = k_reg;
            begin_x_next   = tbl_x;
            begin_y_next   = tbl_y;
            k_next         = '0;
          end else if (last_k) begin
            state_next = WAIT_B;
            miss_next  = 1'b1;
            k_next     = '0;
          end else begin
            k_next = k_reg + IDX_W'(1);
          end
        end
        SCAN_E: begin
          if (hit && (k_reg != begin_idx_reg)) begin
            state_next   = PAIR;
            end_idx_next = k_reg;
            end_x_next   = tbl_x;
            end_y_next   = tbl_y;
            k_next       = '0;
          end else if (hit || last_k) begin
            // Landing first on the begin station still ends the scan: the
            // pick is rejected rather than searching on for a later match.
            state_next = WAIT_E;
            miss_next  = 1'b1;
            k_next     = '0;
          end else begin
            k_next = k_reg + IDX_W'(1);
          end
        end
        PAIR: begin
          if (pair_ready) begin
            state_next     = WAIT_B;
            begin_set_next = 1'b0;
          end
        end
        default: begin
          state_next     = WAIT_B;
          begin_set_next = 1'b0;
          k_next         = '0;
        end
      endcase
    end
  end

  assign tbl_addr   = scanning ? k_reg : '0;
  assign busy       = scanning;
  assign miss       = miss_reg;
  assign begin_set  = begin_set_reg;
  assign begin_idx  = begin_idx_reg;
  assign begin_x    = begin_x_reg;
  assign begin_y    = begin_y_reg;
  assign end_idx    = end_idx_reg;
  assign end_x      = end_x_reg;
  assign end_y      = end_y_reg;
  assign pair_valid = (state_reg == PAIR);

endmodule

// File: tb/tb_station_select.sv
// Testbench for station_select: directed scenarios plus a randomized run,
// all checked against a behavioural model of the selection rules.
module tb_station_select;

  localparam int         N     = 44;
  localparam int         IW    = 6;
  localparam int         CW    = 10;
  localparam int         R     = 1;
  localparam logic [7:0] ENTER = 8'd40;
  localparam logic [7:0] ESC   = 8'd41;

  logic          clk;
  logic          rst_n;
  logic [7:0]    keycode;
  logic [CW-1:0] cursor_x, cursor_y;
  logic [IW-1:0] tbl_addr;
  logic [CW-1:0] tbl_x, tbl_y;
  logic          busy, miss, begin_set, pair_valid, pair_ready;
  logic [IW-1:0] begin_idx, end_idx;
  logic [CW-1:0] begin_x, begin_y, end_x, end_y;

  logic [CW-1:0] tx [0:N-1];
  logic [CW-1:0] ty [0:N-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 = nothing chosen, 1 = begin chosen, 2 = pair offered
  int            m_phase;
  int            m_begin_idx, m_end_idx;
  logic [CW-1:0] m_begin_x, m_begin_y, m_end_x, m_end_y;

  station_select #(
    .N_STATIONS(N), .IDX_W(IW), .COORD_W(CW), .HIT_R(R),
    .ENTER_CODE(ENTER), .ESC_CODE(ESC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .tbl_addr(tbl_addr), .tbl_x(tbl_x), .tbl_y(tbl_y),
    .busy(busy), .miss(miss), .begin_set(begin_set),
    .begin_idx(begin_idx), .begin_x(begin_x), .begin_y(begin_y),
    .end_idx(end_idx), .end_x(end_x), .end_y(end_y),
    .pair_valid(pair_valid), .pair_ready(pair_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tbl_x = '0;
    tbl_y = '0;
    if (int'(tbl_addr) < N) begin
      tbl_x = tx[int'(tbl_addr)];
      tbl_y = ty[int'(tbl_addr)];
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lowest station index within R pixels of (cx,cy) on both axes, else -1.
  function automatic int model_find(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    int dxi, dyi;
    for (int i = 0; i < N; i++) begin
      dxi = int'(cx) - int'(tx[i]);
      dyi = int'(cy) - int'(ty[i]);
      if (dxi < 0) dxi = -dxi;
      if (dyi < 0) dyi = -dyi;
      if (dxi <= R && dyi <= R) return i;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] pick_coord();
    logic [CW-1:0] vals [0:6];
    vals = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd1021, 10'd1022, 10'd1023};
    return vals[$urandom_range(6, 0)];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_begin_idx = 0; m_end_idx = 0;
    m_begin_x = '0; m_begin_y = '0; m_end_x = '0; m_end_y = '0;
  endtask

  task automatic far_table();
    for (int i = 0; i < N; i++) begin
      tx[i] = CW'(10 * i);
      ty[i] = 10'd900;
    end
    tx[3] = 10'd465; ty[3] = 10'd186;
    tx[7] = 10'd530; ty[7] = 10'd301;
    tx[5] = 10'd436; ty[5] = 10'd416;
    tx[6] = 10'd436; ty[6] = 10'd416;
  endtask

  // Press Enter for one cycle at the current cursor and follow the scan
  // cycle by cycle until its outcome, comparing against the model.
  task automatic run_scan(input string tag, input bit do_esc, input int reenter_at);
    int hit, endtick, esc_at;
    bit is_end, same;
    is_end  = (m_phase == 1);
    hit     = model_find(cursor_x, cursor_y);
    same    = is_end && (hit >= 0) && (hit == m_begin_idx);
    endtick = (hit >= 0) ? hit + 2 : N + 1;
    esc_at  = do_esc ? int'($urandom_range(endtick - 1, 1)) : -1;
    keycode = ENTER;
    for (int n = 1; n <= endtick; n++) begin
      tick();
      if (n == 1) begin
        keycode  = 8'd0;
        cursor_x = CW'($urandom);
        cursor_y = CW'($urandom);
      end
      if (n < endtick) begin
        n_checks++;
        if (busy !== 1'b1 || tbl_addr !== IW'(n - 1) || miss !== 1'b0 || pair_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s scan_cycle%0d: busy=%b addr=%0d miss=%b pv=%b, required busy=1 addr=%0d miss=0 pv=0",
                   tag, n, busy, tbl_addr, miss, pair_valid, n - 1);
        end
        if (n == esc_at) begin
          keycode = ESC;
          tick();
          keycode = 8'd0;
          n_checks++;
          if (busy !== 1'b0 || begin_set !== 1'b0 || miss !== 1'b0 || pair_valid !== 1'b0 || tbl_addr !== '0) begin
            n_fail++;
            $display("FAIL %s esc_abort: busy=%b bset=%b miss=%b pv=%b addr=%0d, required all 0",
                     tag, busy, begin_set, miss, pair_valid, tbl_addr);
          end
          m_phase = 0;
          $display("%s: scan aborted by escape at cycle %0d", tag, n + 1);
          tick();
          return;
        end
        if (reenter_at > 0) begin
          if (n == reenter_at + 1) keycode = ENTER;
          else if (n == reenter_at + 2) keycode = 8'd0;
        end
      end else if (hit < 0 || same) begin
        n_checks++;
        if (miss !== 1'b1 || busy !== 1'b0 || pair_valid !== 1'b0 || begin_set !== (m_phase != 0) ||
            begin_idx !== IW'(m_begin_idx)) begin
          n_fail++;
          $display("FAIL %s miss_outcome: miss=%b busy=%b pv=%b bset=%b bidx=%0d, required miss=1 busy=0 pv=0 bset=%b bidx=%0d",
                   tag, miss, busy, pair_valid, begin_set, begin_idx, m_phase != 0, m_begin_idx);
        end
        tick();
        n_checks++;
        if (miss !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s miss_pulse_width: miss=%b busy=%b, required 0 0", tag, miss, busy);
        end
        $display("%s: miss after %0d cycles (same_as_begin=%0b)", tag, endtick - 1, same);
      end else if (!is_end) begin
        n_checks++;
        if (begin_idx !== IW'(hit) || begin_x !== tx[hit] || begin_y !== ty[hit] || begin_set !== 1'b1 ||
            busy !== 1'b0 || miss !== 1'b0 || pair_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s begin_capture: idx=%0d x=%0d y=%0d bset=%b busy=%b miss=%b, required idx=%0d x=%0d y=%0d bset=1 busy=0 miss=0",
                   tag, begin_idx, begin_x, begin_y, begin_set, busy, miss, hit, tx[hit], ty[hit]);
        end
        m_phase = 1; m_begin_idx = hit; m_begin_x = tx[hit]; m_begin_y = ty[hit];
        $display("%s: begin station %0d captured", tag, hit);
      end else begin
        n_checks++;
        if (pair_valid !== 1'b1 || end_idx !== IW'(hit) || end_x !== tx[hit] || end_y !== ty[hit] ||
            begin_idx !== IW'(m_begin_idx) || begin_set !== 1'b1 || busy !== 1'b0 || miss !== 1'b0) begin
          n_fail++;
          $display("FAIL %s end_capture: pv=%b eidx=%0d x=%0d y=%0d bidx=%0d busy=%b, required pv=1 eidx=%0d x=%0d y=%0d bidx=%0d busy=0",
                   tag, pair_valid, end_idx, end_x, end_y, begin_idx, busy, hit, tx[hit], ty[hit], m_begin_idx);
        end
        m_phase = 2; m_end_idx = hit; m_end_x = tx[hit]; m_end_y = ty[hit];
        $display("%s: end station %0d captured, pair offered", tag, hit);
      end
    end
  endtask

  task automatic do_accept(input string tag);
    pair_ready = 1'b1;
    tick();
    pair_ready = 1'b0;
    n_checks++;
    if (pair_valid !== 1'b0 || begin_set !== 1'b0 || end_idx !== IW'(m_end_idx) || begin_idx !== IW'(m_begin_idx)) begin
      n_fail++;
      $display("FAIL %s accept: pv=%b bset=%b eidx=%0d bidx=%0d, required pv=0 bset=0 eidx=%0d bidx=%0d",
               tag, pair_valid, begin_set, end_idx, begin_idx, m_end_idx, m_begin_idx);
    end
    m_phase = 0;
    $display("%s: pair accepted", tag);
  endtask

  task automatic do_esc(input string tag);
    keycode = ESC;
    tick();
    keycode = 8'd0;
    n_checks++;
    if (begin_set !== 1'b0 || pair_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s escape: bset=%b pv=%b busy=%b, required 0 0 0", tag, begin_set, pair_valid, busy);
    end
    m_phase = 0;
    $display("%s: escape, selection cleared", tag);
    tick();
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    if ({tbl_addr, busy, miss, begin_set, begin_idx, begin_x, begin_y,
         end_idx, end_x, end_y, pair_valid} !== '0) begin
      n_fail++;
      $display("FAIL %s reset_values: addr=%0d busy=%b miss=%b bset=%b bidx=%0d bx=%0d by=%0d eidx=%0d ex=%0d ey=%0d pv=%b, required all 0",
               tag, tbl_addr, busy, miss, begin_set, begin_idx, begin_x, begin_y, end_idx, end_x, end_y, pair_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keycode = 8'd0; pair_ready = 1'b0;
    cursor_x = 10'd465; cursor_y = 10'd186;
    far_table();
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    // Enter held through reset release fires on the first clock.
    keycode = ENTER;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || tbl_addr !== '0) begin
      n_fail++;
      $display("FAIL reset held_key_edge: busy=%b addr=%0d, required busy=1 addr=0", busy, tbl_addr);
    end
    $display("reset: key held at release starts scan");
    do_esc("reset");
  endtask

  task automatic test_begin_end();
    far_table();
    cursor_x = 10'd466; cursor_y = 10'd185;
    run_scan("begin_end_b", 1'b0, -1);
    cursor_x = 10'd529; cursor_y = 10'd302;
    run_scan("begin_end_e", 1'b0, -1);
    do_accept("begin_end");
  endtask

  task automatic test_radius();
    cursor_x = 10'd467; cursor_y = 10'd186;
    run_scan("radius_out", 1'b0, -1);
    cursor_x = 10'd464; cursor_y = 10'd187;
    run_scan("radius_in", 1'b0, -1);
    do_esc("radius");
  endtask

  task automatic test_overlap();
    cursor_x = 10'd436; cursor_y = 10'd416;
    run_scan("overlap_b", 1'b0, -1);
    cursor_x = 10'd436; cursor_y = 10'd416;
    run_scan("overlap_same", 1'b0, -1);
    do_esc("overlap");
  endtask

  task automatic test_held_key();
    int busy_cnt;
    busy_cnt = 0;
    cursor_x = 10'd465; cursor_y = 10'd186;
    keycode = ENTER;
    repeat (200) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    keycode = 8'd0;
    n_checks++;
    if (busy_cnt != 4 || begin_set !== 1'b1 || begin_idx !== 6'd3) begin
      n_fail++;
      $display("FAIL held_key: busy_cycles=%0d bset=%b bidx=%0d, required busy_cycles=4 bset=1 bidx=3",
               busy_cnt, begin_set, begin_idx);
    end
    m_phase = 1; m_begin_idx = 3; m_begin_x = 10'd465; m_begin_y = 10'd186;
    $display("held_key: one scan over 200 held cycles, busy %0d cycles", busy_cnt);
    tick();
    cursor_x = 10'd1000; cursor_y = 10'd1000;
    run_scan("mid_scan_enter", 1'b0, 5);
    do_esc("held_key");
  endtask

  task automatic test_back_to_back();
    cursor_x = 10'd465; cursor_y = 10'd186;
    run_scan("bp_b", 1'b0, -1);
    cursor_x = 10'd530; cursor_y = 10'd301;
    run_scan("bp_e", 1'b0, -1);
    for (int c = 0; c < 50; c++) begin
      tick();
      n_checks++;
      if (pair_valid !== 1'b1 || begin_idx !== IW'(m_begin_idx) || end_idx !== IW'(m_end_idx) ||
          begin_x !== m_begin_x || end_y !== m_end_y || begin_set !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure cycle%0d: pv=%b bidx=%0d eidx=%0d, required pv=1 bidx=%0d eidx=%0d",
                 c, pair_valid, begin_idx, end_idx, m_begin_idx, m_end_idx);
      end
    end
    $display("backpressure: pair held 50 cycles");
    keycode = ESC; pair_ready = 1'b1;
    tick();
    keycode = 8'd0; pair_ready = 1'b0;
    n_checks++;
    if (pair_valid !== 1'b0 || begin_set !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL esc_with_ready: pv=%b bset=%b busy=%b, required 0 0 0", pair_valid, begin_set, busy);
    end
    m_phase = 0;
    $display("backpressure: escape with ready drops pair");
    tick();
  endtask

  task automatic test_async_reset();
    int guard;
    cursor_x = 10'd1000; cursor_y = 10'd1000;
    keycode = ENTER;
    tick();
    keycode = 8'd0;
    guard = 0;
    while (tbl_addr !== 6'd10 && guard < 40) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard != 10) begin
      n_fail++;
      $display("FAIL async_reset reach_k10: cycles=%0d, required 10", guard);
    end
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("async_reset: outputs cleared mid-scan");
    cursor_x = 10'd465; cursor_y = 10'd186;
    run_scan("after_reset", 1'b0, -1);
    do_esc("after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) begin
      tx[i] = pick_coord();
      ty[i] = pick_coord();
    end
    for (int it = 0; it < 40; it++) begin
      if (m_phase == 2) begin
        if ($urandom_range(3, 0) != 0) do_accept("random");
        else do_esc("random");
      end else begin
        cursor_x = pick_coord();
        cursor_y = pick_coord();
        run_scan("random", ($urandom_range(4, 0) == 0), -1);
      end
    end
    do_esc("random");
  endtask

  initial begin
    test_reset();
    test_begin_end();
    test_radius();
    test_overlap();
    test_held_key();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
